// File: rtl/tri_scan_ring_loader.sv
// ============================================================================
// Module      : tri_scan_ring_loader
// Description : Serial loader/readback engine for a scan-only latch config ring.
//               Optional readback check enabled by macro SCAN_RING_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tri_scan_ring_loader #(
    parameter int WIDTH = 16,
    parameter int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire              vd,
    inout  wire              gd,
    input  logic             load_val,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_rdy,
    output logic             ring_si,
    input  logic             ring_so,
    output logic             shift_act,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_val,
    output logic             chk_err
);

    localparam logic [CNTW-1:0] C_LAST = CNTW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-2:0]   r_sreg;     // bits still waiting to go out, [0] next
    logic [WIDTH-2:0]   r_cap;      // returned bits collected so far
    logic [WIDTH-1:0]   w_cap_nxt;
    logic [WIDTH-1:0]   r_rd_data;
    logic [CNTW-1:0]    r_cnt;
    logic               r_ring_si;
    logic               w_accept;
    logic               w_last;
    wire                unused_pwr;

    assign unused_pwr = vd ^ gd;
    assign w_last     = (r_cnt == C_LAST);
    assign w_accept   = load_val & load_rdy;
    assign w_cap_nxt  = {ring_so, r_cap};
    assign ring_si    = r_ring_si;
    assign rd_data    = r_rd_data;

    always_comb begin
        w_state_nxt = r_state;
        load_rdy    = 1'b0;
        shift_act   = 1'b0;
        rd_val      = 1'b0;
        case (r_state)
            S_IDLE: begin
                load_rdy = ~rst;
                if (load_val) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_act = ~rst;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                rd_val      = ~rst;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sreg    <= '0;
            r_cap     <= '0;
            r_rd_data <= '0;
            r_cnt     <= '0;
            r_ring_si <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_ring_si <= load_data[0];
                r_sreg    <= load_data[WIDTH-1:1];
                r_cnt     <= '0;
            end else if (r_state == S_SHIFT) begin
                r_cap <= w_cap_nxt[WIDTH-1:1];
                r_cnt <= r_cnt + CNTW'(1);
                // On the final shift the last data bit stays parked on ring_si.
                if (w_last) begin
                    r_rd_data <= w_cap_nxt;
                end else begin
                    r_ring_si <= r_sreg[0];
                    r_sreg    <= r_sreg >> 1;
                end
            end
        end
    end

`ifdef SCAN_RING_CHECK_EN
    logic [WIDTH-1:0] r_cur;
    logic [WIDTH-1:0] r_shadow;
    logic             r_shadow_vld;
    logic             r_chk_err;

    // The ring should hand back exactly what the previous load put in it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur        <= '0;
            r_shadow     <= '0;
            r_shadow_vld <= 1'b0;
            r_chk_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cur <= load_data;
            end
            if (r_state == S_DONE) begin
                if (r_shadow_vld && (r_rd_data != r_shadow)) begin
                    r_chk_err <= 1'b1;
                end
                r_shadow     <= r_cur;
                r_shadow_vld <= 1'b1;
            end
        end
    end

    assign chk_err = r_chk_err;
`else
    assign chk_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tri_scan_ring_loader.sv
// Self-checking bench for tri_scan_ring_loader (WIDTH=8) with a behavioural ring model.
`default_nettype none

module tb_tri_scan_ring_loader;

    logic       clk;
    logic       rst;
    logic       load_val;
    logic [7:0] load_data;
    logic       load_rdy;
    logic       ring_si;
    logic       ring_so;
    logic       shift_act;
    logic [7:0] rd_data;
    logic       rd_val;
    logic       chk_err;
    wire        vd = 1'b1;
    wire        gd = 1'b0;

    int errors = 0;
    int checks = 0;

`ifdef SCAN_RING_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    // Physical ring: 8 latches, scan_out from [0], shifting when enabled.
    logic [7:0] chain = 8'h00;
    logic       flip_req;
    logic [7:0] flip_mask;
    assign ring_so = chain[0];
    always @(posedge clk) begin
        if (shift_act)     chain <= {ring_si, chain[7:1]};
        else if (flip_req) chain <= chain ^ flip_mask;
    end

    // Reference view: ring contents, last readback word, check state.
    logic [7:0] model_ring = 8'h00;
    logic [7:0] prev_rd    = 8'h00;
    bit         rd_known   = 1'b1;
    bit         shadow_vld = 1'b0;
    logic [7:0] shadow     = 8'h00;
    bit         exp_chk    = 1'b0;

    tri_scan_ring_loader #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .vd(vd), .gd(gd),
        .load_val(load_val), .load_data(load_data), .load_rdy(load_rdy),
        .ring_si(ring_si), .ring_so(ring_so), .shift_act(shift_act),
        .rd_data(rd_data), .rd_val(rd_val), .chk_err(chk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic do_load(input logic [7:0] word, input bit hold, input bit check_rd);
        logic [7:0] exp_rd;
        exp_rd = model_ring;
        @(negedge clk);
        checks++;
        if (load_rdy !== 1'b1) begin
            errors++; $display("FAIL rdy_before_load: got %b want 1", load_rdy);
        end
        load_val  = 1'b1;
        load_data = word;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (hold) load_data = 8'($urandom);
            else      load_val  = 1'b0;
            checks++;
            if (shift_act !== 1'b1) begin
                errors++; $display("FAIL shift_act k=%0d: got %b want 1", k, shift_act);
            end
            checks++;
            if (ring_si !== word[k-1]) begin
                errors++; $display("FAIL ring_si k=%0d word=%h: got %b want %b", k, word, ring_si, word[k-1]);
            end
            checks++;
            if (load_rdy !== 1'b0) begin
                errors++; $display("FAIL rdy_busy k=%0d: got %b want 0", k, load_rdy);
            end
            checks++;
            if (rd_val !== 1'b0) begin
                errors++; $display("FAIL rd_val_early k=%0d: got %b want 0", k, rd_val);
            end
            if (rd_known) begin
                checks++;
                if (rd_data !== prev_rd) begin
                    errors++; $display("FAIL rd_data_hold k=%0d: got %h want %h", k, rd_data, prev_rd);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (rd_val !== 1'b1) begin
            errors++; $display("FAIL rd_val_pulse: got %b want 1", rd_val);
        end
        checks++;
        if (shift_act !== 1'b0 || load_rdy !== 1'b0) begin
            errors++; $display("FAIL done_ctrl: got shift_act=%b load_rdy=%b want 0 0", shift_act, load_rdy);
        end
        if (check_rd) begin
            checks++;
            if (rd_data !== exp_rd) begin
                errors++; $display("FAIL rd_data: got %h want %h", rd_data, exp_rd);
            end
        end
        if (CHECK_EN && shadow_vld && exp_rd != shadow) exp_chk = 1'b1;
        shadow     = word;
        shadow_vld = 1'b1;
        model_ring = word;
        prev_rd    = exp_rd;
        rd_known   = check_rd;
        @(negedge clk);
        checks++;
        if (load_rdy !== 1'b1 || rd_val !== 1'b0) begin
            errors++; $display("FAIL after_done: got load_rdy=%b rd_val=%b want 1 0", load_rdy, rd_val);
        end
        checks++;
        if (chk_err !== exp_chk) begin
            errors++; $display("FAIL chk_err: got %b want %b", chk_err, exp_chk);
        end
        checks++;
        if (ring_si !== word[7]) begin
            errors++; $display("FAIL ring_si_hold: got %b want %b", ring_si, word[7]);
        end
        if (rd_known) begin
            checks++;
            if (rd_data !== prev_rd) begin
                errors++; $display("FAIL rd_data_after: got %h want %h", rd_data, prev_rd);
            end
        end
        load_val = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({load_rdy, ring_si, shift_act, rd_val, chk_err} !== 5'b0 || rd_data !== 8'h00) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d: got rdy=%b si=%b sa=%b rv=%b ce=%b rd=%h want all 0",
                         i, load_rdy, ring_si, shift_act, rd_val, chk_err, rd_data);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (load_rdy !== 1'b1) begin
            errors++; $display("FAIL reset_release_rdy: got %b want 1", load_rdy);
        end
    endtask

    task automatic test_first_load();
        do_load(8'hA5, 1'b0, 1'b1);
    endtask

    task automatic test_second_load();
        do_load(8'h3C, 1'b0, 1'b1);
    endtask

    task automatic test_random_loads();
        for (int i = 0; i < 6; i++) begin
            do_load(8'($urandom), 1'b0, 1'b1);
            repeat ($urandom_range(2)) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back_hold();
        do_load(8'($urandom), 1'b1, 1'b1);
        do_load(8'($urandom), 1'b1, 1'b1);
    endtask

    task automatic test_abort();
        logic [7:0] w;
        w = 8'($urandom);
        @(negedge clk);
        load_val  = 1'b1;
        load_data = w;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            load_val = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (rd_val !== 1'b0 || rd_data !== 8'h00 || shift_act !== 1'b0 || load_rdy !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: got rv=%b rd=%h sa=%b rdy=%b want 0 00 0 0", rd_val, rd_data, shift_act, load_rdy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (load_rdy !== 1'b1) begin
            errors++; $display("FAIL abort_idle_rdy: got %b want 1", load_rdy);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (rd_val !== 1'b0 || shift_act !== 1'b0) begin
                errors++; $display("FAIL abort_quiet cyc=%0d: got rv=%b sa=%b want 0 0", i, rd_val, shift_act);
            end
        end
        shadow_vld = 1'b0;
        exp_chk    = 1'b0;
        prev_rd    = 8'h00;
        rd_known   = 1'b1;
        do_load(8'($urandom), 1'b0, 1'b0);
        do_load(8'($urandom), 1'b0, 1'b1);
    endtask

    task automatic test_chk_err();
        logic [7:0] m;
        do_load(8'($urandom), 1'b0, 1'b1);
        m = 8'h01 << $urandom_range(7);
        @(negedge clk);
        flip_mask = m;
        flip_req  = 1'b1;
        @(negedge clk);
        flip_req   = 1'b0;
        model_ring = model_ring ^ m;
        do_load(8'($urandom), 1'b0, 1'b1);
        do_load(8'($urandom), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (chk_err !== exp_chk) begin
                errors++; $display("FAIL chk_err_sticky cyc=%0d: got %b want %b", i, chk_err, exp_chk);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_chk    = 1'b0;
        shadow_vld = 1'b0;
        prev_rd    = 8'h00;
        rd_known   = 1'b1;
        #1;
        checks++;
        if (chk_err !== 1'b0 || rd_data !== 8'h00) begin
            errors++; $display("FAIL chk_err_cleared: got ce=%b rd=%h want 0 00", chk_err, rd_data);
        end
    endtask

    initial begin
        rst       = 1'b1;
        load_val  = 1'b0;
        load_data = 8'h00;
        flip_req  = 1'b0;
        flip_mask = 8'h00;
        test_reset();
        test_first_load();
        test_second_load();
        test_random_loads();
        test_back_to_back_hold();
        test_abort();
        test_chk_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
